// File: rtl/reverb_comb_mc.sv
// rtl/reverb_comb_mc.sv - multichannel feedback-comb reverb with self-clearing per-channel delay RAM
// Optional saturation (and sticky clip_flag) enabled by defining REVERB_COMB_MC_SAT_EN.
module reverb_comb_mc #(
    parameter int G_DATA_WIDTH       = 16,
    parameter int G_NUM_CHANNELS     = 2,
    parameter int G_DELAY_DEPTH_LOG2 = 12
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          bypass,
    input  logic [G_DELAY_DEPTH_LOG2-1:0] delay_len,
    input  logic [15:0]                   feedback_gain,
    input  logic [15:0]                   dry_gain,
    input  logic [15:0]                   wet_gain,
    input  logic [G_DATA_WIDTH-1:0]       din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic                          din_last,
    output logic [G_DATA_WIDTH-1:0]       dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          dout_last,
    output logic                          clip_flag
);

    localparam int DW    = G_DATA_WIDTH;
    localparam int N     = G_DELAY_DEPTH_LOG2;
    localparam int C     = G_NUM_CHANNELS;
    localparam int CW    = (C > 1) ? $clog2(C) : 1;
    localparam int AW    = CW + N;
    localparam int DEPTH = C * (2 ** N);
    localparam int P     = DW + 17;
    localparam int SW    = P + 1;

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_READ, S_CALC, S_OUT} state_t;

    state_t                state, state_nx;
    logic [AW-1:0]         clr_cnt;
    logic [CW-1:0]         ch;
    logic [N-1:0]          wr_ptr;
    logic [N-1:0]          dl_eff;
    logic [AW-1:0]         rd_addr;
    logic signed [DW-1:0]  x_q;
    logic signed [DW-1:0]  d_q;
    logic [DW-1:0]         s_q;
    logic [DW-1:0]         y_q;
    logic                  out_first;
    logic                  bypass_act;
    logic                  accept;
    logic                  ch_wrap;
    logic                  mem_we;
    logic [AW-1:0]         mem_wa;
    logic [DW-1:0]         mem_wd;
    logic [DW-1:0]         mem [0:DEPTH-1];

    logic signed [P-1:0]   fb_prod, fb_sh, dry_prod, wet_prod;
    logic signed [SW-1:0]  s_full, y_acc, y_full;
    logic [DW-1:0]         s_val, y_val;

    function automatic logic signed [P-1:0] mulg(input logic signed [DW-1:0] a, input logic [15:0] g);
        logic signed [P-1:0] ae, ge;
        ae = {{(P-DW){a[DW-1]}}, a};
        ge = {{(P-16){1'b0}}, g};
        return ae * ge;
    endfunction

    assign bypass_act = bypass && ((state == S_IDLE) || (state == S_CLEAR));
    assign accept     = (state == S_IDLE) && enable && !bypass && din_valid;
    assign ch_wrap    = (ch == CW'(C - 1));
    assign dl_eff     = (delay_len == '0) ? {{(N-1){1'b0}}, 1'b1} : delay_len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_CLEAR;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        din_ready  = 1'b0;
        dout       = '0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        case (state)
            S_CLEAR: if (clr_cnt == AW'(DEPTH - 1)) state_nx = S_IDLE;
            S_IDLE: begin
                din_ready = enable;
                if (accept) state_nx = S_READ;
            end
            S_READ: state_nx = S_CALC;
            S_CALC: state_nx = S_OUT;
            S_OUT: begin
                dout       = y_q;
                dout_valid = 1'b1;
                dout_last  = ch_wrap;
                if (dout_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_CLEAR;
        endcase
        if (bypass_act) begin
            dout       = din;
            dout_valid = din_valid;
            dout_last  = din_last;
            din_ready  = dout_ready;
        end
        // Dropping enable abandons any in-flight sample and restarts the sweep.
        if (!enable) state_nx = S_CLEAR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt   <= '0;
            ch        <= '0;
            wr_ptr    <= '0;
            rd_addr   <= '0;
            x_q       <= '0;
            s_q       <= '0;
            y_q       <= '0;
            out_first <= 1'b0;
        end else if (!enable) begin
            clr_cnt   <= '0;
            ch        <= '0;
            wr_ptr    <= '0;
            out_first <= 1'b0;
        end else begin
            if (state == S_CLEAR) clr_cnt <= clr_cnt + AW'(1);
            if (accept) begin
                x_q     <= $signed(din);
                rd_addr <= {ch, wr_ptr - dl_eff};
            end
            if (state == S_CALC) begin
                s_q       <= s_val;
                y_q       <= y_val;
                out_first <= 1'b1;
            end
            if (state == S_OUT) begin
                out_first <= 1'b0;
                if (dout_ready) begin
                    if (ch_wrap) begin
                        ch     <= '0;
                        wr_ptr <= wr_ptr + N'(1);
                    end else begin
                        ch <= ch + CW'(1);
                    end
                end
            end
        end
    end

    assign mem_we = enable && ((state == S_CLEAR) || ((state == S_OUT) && out_first));
    assign mem_wa = (state == S_CLEAR) ? clr_cnt : {ch, wr_ptr};
    assign mem_wd = (state == S_CLEAR) ? '0 : s_q;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        if (state == S_READ) d_q <= $signed(mem[rd_addr]);
    end

    assign fb_prod  = mulg(d_q, feedback_gain);
    assign dry_prod = mulg(x_q, dry_gain);
    assign wet_prod = mulg(d_q, wet_gain);
    assign fb_sh    = fb_prod >>> 15;
    assign s_full   = {fb_sh[P-1], fb_sh} + {{(SW-DW){x_q[DW-1]}}, x_q};
    assign y_acc    = {dry_prod[P-1], dry_prod} + {wet_prod[P-1], wet_prod};
    assign y_full   = y_acc >>> 15;

`ifdef REVERB_COMB_MC_SAT_EN
    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
    logic ovf_s, ovf_y;

    // Value fits DW bits only if every bit from DW-1 upward matches the sign.
    assign ovf_s = !((&s_full[SW-1:DW-1]) || !(|s_full[SW-1:DW-1]));
    assign ovf_y = !((&y_full[SW-1:DW-1]) || !(|y_full[SW-1:DW-1]));
    assign s_val = ovf_s ? (s_full[SW-1] ? SMIN : SMAX) : s_full[DW-1:0];
    assign y_val = ovf_y ? (y_full[SW-1] ? SMIN : SMAX) : y_full[DW-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                  clip_flag <= 1'b0;
        else if (!enable)                              clip_flag <= 1'b0;
        else if ((state == S_CALC) && (ovf_s || ovf_y)) clip_flag <= 1'b1;
    end
`else
    logic unused_hi;

    assign s_val     = s_full[DW-1:0];
    assign y_val     = y_full[DW-1:0];
    assign unused_hi = ^{s_full[SW-1:DW], y_full[SW-1:DW]};
    assign clip_flag = 1'b0;
`endif

endmodule
